// File: rtl/nn_pkg.sv
// Shared types and default constants for the neuron driver and the layer logic around it.
package nn_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    CAPTURE
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FRAC_BITS  = 4;
  localparam int DEF_TAG_WIDTH  = 8;

  // Cycles from the Run-high cycle to the first cycle in which the current neuron pipeline holds Y.
  localparam int NN_NEURON_LATENCY = 7;

endpackage

// File: rtl/neuron_driver.sv
// Initiator for one fixed-latency neuron: accepts vectors, issues Run, captures Y after the
// pipeline latency and returns it with a sample tag through a one-deep result buffer.
module neuron_driver
  import nn_pkg::*;
#(
  parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
  parameter int FRAC_BITS      = DEF_FRAC_BITS,
  parameter int NEURON_LATENCY = NN_NEURON_LATENCY,
  parameter int TAG_WIDTH      = DEF_TAG_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [4*DATA_WIDTH-1:0]      in_x,
  output logic                         neu_en,
  output logic                         neu_run,
  output logic signed [DATA_WIDTH-1:0] neu_x1,
  output logic signed [DATA_WIDTH-1:0] neu_x2,
  output logic signed [DATA_WIDTH-1:0] neu_x3,
  output logic signed [DATA_WIDTH-1:0] neu_x4,
  input  logic signed [DATA_WIDTH-1:0] neu_y,
  output logic                         res_valid,
  input  logic                         res_ready,
  output logic signed [DATA_WIDTH-1:0] res_y,
  output logic [TAG_WIDTH-1:0]         res_tag,
  output logic                         busy
);

  localparam int CNT_W = $clog2(NEURON_LATENCY) + 1;

  if (NEURON_LATENCY < 2 || FRAC_BITS >= DATA_WIDTH) begin : g_param_check
    $error("neuron_driver: NEURON_LATENCY must be >= 2 and FRAC_BITS < DATA_WIDTH");
  end

  state_t                       r_state;
  state_t                       w_state_next;
  logic [CNT_W-1:0]             r_lat_cnt;
  logic [CNT_W-1:0]             w_cnt_next;
  logic [TAG_WIDTH-1:0]         r_tag_cnt;
  logic [TAG_WIDTH-1:0]         r_res_tag;
  logic signed [DATA_WIDTH-1:0] r_x1;
  logic signed [DATA_WIDTH-1:0] r_x2;
  logic signed [DATA_WIDTH-1:0] r_x3;
  logic signed [DATA_WIDTH-1:0] r_x4;
  logic signed [DATA_WIDTH-1:0] r_res_y;
  logic                         r_res_valid;
  logic                         w_accept;
  logic                         w_capture;

  assign w_cnt_next = r_lat_cnt + CNT_W'(1);

  // WAIT leaves when the counter reaches LATENCY-1, which puts CAPTURE on cycle NEURON_LATENCY.
  always_comb begin
    w_state_next = r_state;
    w_accept     = 1'b0;
    w_capture    = 1'b0;
    in_ready     = 1'b0;
    neu_run      = 1'b0;
    neu_en       = 1'b1;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        neu_en   = 1'b0;
        if (in_valid) begin
          w_accept     = 1'b1;
          w_state_next = ISSUE;
        end
      end
      ISSUE: begin
        neu_run      = 1'b1;
        w_state_next = WAIT;
      end
      WAIT: begin
        if (w_cnt_next == CNT_W'(NEURON_LATENCY - 1)) w_state_next = CAPTURE;
      end
      CAPTURE: begin
        if (!r_res_valid || res_ready) begin
          w_capture    = 1'b1;
          w_state_next = IDLE;
        end
      end
      default: begin
        neu_en       = 1'b0;
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_lat_cnt <= '0;
      r_tag_cnt <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == ISSUE) r_lat_cnt <= '0;
      else if (r_state == WAIT) r_lat_cnt <= w_cnt_next;
      if (w_capture) r_tag_cnt <= r_tag_cnt + TAG_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_x1 <= '0;
      r_x2 <= '0;
      r_x3 <= '0;
      r_x4 <= '0;
    end else if (w_accept) begin
      r_x1 <= in_x[0*DATA_WIDTH +: DATA_WIDTH];
      r_x2 <= in_x[1*DATA_WIDTH +: DATA_WIDTH];
      r_x3 <= in_x[2*DATA_WIDTH +: DATA_WIDTH];
      r_x4 <= in_x[3*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // A capture may refill the buffer in the same cycle the consumer drains it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_res_valid <= 1'b0;
      r_res_y     <= '0;
      r_res_tag   <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_y     <= neu_y;
      r_res_tag   <= r_tag_cnt;
    end else if (res_ready) begin
      r_res_valid <= 1'b0;
    end
  end

  assign neu_x1    = r_x1;
  assign neu_x2    = r_x2;
  assign neu_x3    = r_x3;
  assign neu_x4    = r_x4;
  assign res_valid = r_res_valid;
  assign res_y     = r_res_y;
  assign res_tag   = r_res_tag;
  assign busy      = (r_state != IDLE);

endmodule

// File: doc/neuron_driver.md
Name: neuron_driver

Overview:
- Initiator side of the fixed-latency neuron interface (Run/En/X1..X4 in, Y out).
- Accepts 4-element input vectors over a valid/ready stream, sequences one neuron evaluation per vector and captures Y after the neuron's fixed latency.
- Returns each result with a sample tag over a valid/ready stream that supports backpressure.
- Sits between the layer input buffer and one neuron instance; a layer instantiates one driver per neuron.

Parameters:
- DATA_WIDTH, 8, fixed-point word width for X and Y (signed).
- FRAC_BITS, 4, fractional bits; passed through for documentation only, not used in arithmetic here.
- NEURON_LATENCY, 7, cycles from the Run-high cycle (cycle 0) to the first cycle in which neuron Y holds the new result.
- TAG_WIDTH, 8, width of the sample tag counter.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input vector valid.
- in_ready  out  1  driver can accept a vector.
- in_x  in  4*DATA_WIDTH  packed signed vector; element k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- neu_en  out  1  neuron enable.
- neu_run  out  1  neuron start pulse.
- neu_x1..neu_x4  out  DATA_WIDTH each  registered operands to the neuron.
- neu_y  in  DATA_WIDTH  neuron result.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_y  out  DATA_WIDTH  captured result.
- res_tag  out  TAG_WIDTH  sample index of res_y.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE; neu_en=0; neu_run=0; neu_x*=0; res_valid=0; res_y=0; res_tag=0; tag counter=0; latency counter=0.
- FSM states: IDLE, ISSUE, WAIT, CAPTURE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch in_x into neu_x1..4 and go to ISSUE.
  - neu_x* are held unchanged until the next accept.
- ISSUE (cycle 0):
  - neu_run=1 for exactly this one cycle; neu_en=1.
  - Clear the latency counter; go to WAIT.
- WAIT:
  - neu_en=1; the counter increments each cycle.
  - When the counter reaches NEURON_LATENCY-1, go to CAPTURE.
  - CAPTURE is therefore cycle NEURON_LATENCY.
- CAPTURE:
  - If the result buffer is empty, or is being drained this cycle (res_valid & res_ready), load res_y<=neu_y and res_tag<=tag counter.
  - In the same case, set res_valid=1, increment the tag counter (wraps modulo 2^TAG_WIDTH) and return to IDLE.
  - Otherwise stay in CAPTURE (stall). Neuron Y is stable while stalled; neu_en stays 1.
- in_ready is 0 outside IDLE; there is one outstanding evaluation at most.
- Result buffer is one deep:
  - res_valid clears on res_ready unless a capture reloads it in the same cycle.
  - res_y and res_tag hold while res_valid=1 and res_ready=0.
- Overlap: a new vector may be accepted while an earlier result is still waiting in the buffer.
- Latency: minimum accept-to-res_valid is NEURON_LATENCY+2 cycles (accept, ISSUE, WAIT..., CAPTURE edge). Sustained throughput is one result per NEURON_LATENCY+2 cycles.
- neu_x* are stable from ISSUE through CAPTURE, covering the neuron's operand-load cycle.
- Width: X and Y pass through untouched; the driver performs no arithmetic on data.
- Reset mid-operation: the driver returns to IDLE immediately and any in-flight result is discarded. The neuron shares rst_n through the layer top, so both sides resynchronise.
- res_ready asserted while res_valid=0 has no effect.

Decomposition:
- Shared package nn_pkg: state enum typedef (IDLE, ISSUE, WAIT, CAPTURE), default DATA_WIDTH/FRAC_BITS constants, and the NEURON_LATENCY constant for the current neuron pipeline.
- No sub-module. The result buffer is inline (a 1-entry register plus valid flag).
- The verification top instantiates neuron_driver plus a neuron or a latency-accurate neuron model.

Test Plan:
- Single vector in_x={4,3,2,1}, res_ready=1 → exactly one neu_run pulse, 1 cycle after accept. res_valid asserts 9 cycles after accept, with res_y equal to neuron Y and res_tag=0.
- Back-to-back: in_valid held high for 3 vectors, res_ready=1 → accepts are spaced 9 cycles apart; tags 0,1,2 appear in order; neu_run is never high for 2 consecutive cycles.
- Backpressure: res_ready=0 across 2 vectors → first result held stable. Second evaluation stalls in CAPTURE with in_ready=0. Raising res_ready for 1 cycle drains result 0, and result 1 loads the same cycle (res_valid stays 1).
- Tag wrap: TAG_WIDTH=2, 5 vectors → tags 0,1,2,3,0.
- Reset mid-WAIT: drop rst_n at cycle 3 after ISSUE → all outputs reset asynchronously, with no res_valid afterwards. A new vector after release completes normally with tag 0.
- Operand stability: a change on in_x while busy → neu_x* are unchanged until the next IDLE accept.
